// File: rtl/simon_if.sv
// Game-side signal bundle for simon_sequencer.
// The slave modport is the sequencer's view. The master modport is the
// surrounding system's view: buttons, LFSR, LEDs and status display.
interface simon_if;
    logic       start;
    logic [3:0] btn_pressed;
    logic [1:0] rnd_color;
    logic       rnd_step;
    logic [1:0] led_color;
    logic       led_enable;
    logic [6:0] level;
    logic       busy;
    logic       lose;
    logic       win;

    modport slave (
        input  start, btn_pressed, rnd_color,
        output rnd_step, led_color, led_enable, level, busy, lose, win
    );

    modport master (
        output start, btn_pressed, rnd_color,
        input  rnd_step, led_color, led_enable, level, busy, lose, win
    );
endinterface

// File: rtl/simon_sequencer.sv
// Simon memory-game sequencer.
// Each round grows the pattern by one random color and plays the whole
// pattern back on the LED. The player must then repeat it on the four buttons.
// Optional feature macro SIMON_TIMEOUT_EN: when it is defined, the player
// loses if no button is pressed for TIMEOUT_TICKS consecutive cycles while
// the sequencer is waiting for an entry.
module simon_sequencer #(
    parameter int MAX_LEN       = 32,
    parameter int STEP_TICKS    = 50000000,
    parameter int GAP_TICKS     = 25000000,
    parameter int TIMEOUT_TICKS = 500000000
) (
    input  logic    clk,
    input  logic    reset,
    simon_if.slave  bus
);

    localparam int IDX_W   = $clog2(MAX_LEN);
    localparam int TMR_MAX = (STEP_TICKS > GAP_TICKS) ? STEP_TICKS : GAP_TICKS;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int ECHO_W  = $clog2(STEP_TICKS + 1);

    localparam logic [TMR_W-1:0]  STEP_LAST = TMR_W'(STEP_TICKS - 1);
    localparam logic [TMR_W-1:0]  GAP_LAST  = TMR_W'(GAP_TICKS - 1);
    localparam logic [ECHO_W-1:0] ECHO_INIT = ECHO_W'(STEP_TICKS);
    localparam logic [6:0]        MAX_LEVEL = 7'(MAX_LEN);

    // Reject parameter sets the datapath widths cannot represent.
    if (MAX_LEN < 2 || MAX_LEN > 64 || STEP_TICKS < 1 || GAP_TICKS < 1 ||
        TIMEOUT_TICKS < 1) begin : g_bad_params
        $error("simon_sequencer: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPEND,
        S_SIMON_PLAY,
        S_SIMON_REST,
        S_PLAYER_WAIT,
        S_PLAYER_CHECK,
        S_LOSE,
        S_WIN
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        level_q, level_d;
    logic [6:0]        idx_q, idx_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [3:0]        press_q, press_d;
    logic [ECHO_W-1:0] echo_cnt_q, echo_cnt_d;
    logic [1:0]        echo_col_q, echo_col_d;
    logic [1:0]        pattern_q [MAX_LEN];
    logic [3:0]        expect_onehot;

`ifdef SIMON_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    // Lowest set bit wins; only used for the echo color, since a
    // multi-bit press loses anyway.
    function automatic logic [1:0] btn_color(input logic [3:0] b);
        logic [1:0] c;
        c = 2'd0;
        if (b[0])      c = 2'd0;
        else if (b[1]) c = 2'd1;
        else if (b[2]) c = 2'd2;
        else if (b[3]) c = 2'd3;
        return c;
    endfunction

    // Next-state logic: game flow, round bookkeeping, phase timers and echo.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        idx_d      = idx_q;
        timer_d    = '0;
        press_d    = press_q;
        echo_cnt_d = (echo_cnt_q != '0) ? echo_cnt_q - 1'b1 : '0;
        echo_col_d = echo_col_q;
`ifdef SIMON_TIMEOUT_EN
        to_cnt_d   = '0;
`endif
        expect_onehot = 4'b0001 << pattern_q[idx_q[IDX_W-1:0]];

        case (state_q)
            S_IDLE, S_LOSE, S_WIN: begin
                if (bus.start) begin
                    state_d = S_APPEND;
                    level_d = '0;
                end
            end
            S_APPEND: begin
                level_d = level_q + 7'd1;
                idx_d   = '0;
                state_d = S_SIMON_PLAY;
            end
            S_SIMON_PLAY: begin
                if (timer_q == STEP_LAST) state_d = S_SIMON_REST;
                else                      timer_d = timer_q + 1'b1;
            end
            S_SIMON_REST: begin
                if (timer_q == GAP_LAST) begin
                    if ((idx_q + 7'd1) < level_q) begin
                        idx_d   = idx_q + 7'd1;
                        state_d = S_SIMON_PLAY;
                    end else begin
                        idx_d   = '0;
                        state_d = S_PLAYER_WAIT;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_PLAYER_WAIT: begin
                if (bus.btn_pressed != 4'b0000) begin
                    press_d    = bus.btn_pressed;
                    echo_cnt_d = ECHO_INIT;
                    echo_col_d = btn_color(bus.btn_pressed);
                    state_d    = S_PLAYER_CHECK;
                end
`ifdef SIMON_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    state_d = S_LOSE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            S_PLAYER_CHECK: begin
                // A multi-bit press can never equal the one-hot expectation.
                if (press_q == expect_onehot) begin
                    idx_d = idx_q + 7'd1;
                    if ((idx_q + 7'd1) == level_q)
                        state_d = (level_q == MAX_LEVEL) ? S_WIN : S_APPEND;
                    else
                        state_d = S_PLAYER_WAIT;
                end else begin
                    state_d = S_LOSE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The echo only belongs to the entry phase; drop it when leaving.
        if (state_d != S_PLAYER_WAIT && state_d != S_PLAYER_CHECK)
            echo_cnt_d = '0;
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            level_q    <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
            press_q    <= '0;
            echo_cnt_q <= '0;
            echo_col_q <= '0;
`ifdef SIMON_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            press_q    <= press_d;
            echo_cnt_q <= echo_cnt_d;
            echo_col_q <= echo_col_d;
`ifdef SIMON_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

    // Pattern store: one new color per round, never cleared by reset.
    always_ff @(posedge clk) begin
        if (state_q == S_APPEND)
            pattern_q[level_q[IDX_W-1:0]] <= bus.rnd_color;
    end

    // Output decode from the registered state.
    always_comb begin
        bus.rnd_step   = 1'b0;
        bus.led_enable = 1'b0;
        bus.led_color  = 2'd0;
        bus.level      = level_q;
        bus.busy       = 1'b1;
        bus.lose       = 1'b0;
        bus.win        = 1'b0;
        case (state_q)
            S_IDLE: bus.busy = 1'b0;
            S_APPEND: bus.rnd_step = 1'b1;
            S_SIMON_PLAY: begin
                bus.led_enable = 1'b1;
                bus.led_color  = pattern_q[idx_q[IDX_W-1:0]];
            end
            S_PLAYER_WAIT, S_PLAYER_CHECK: begin
                bus.led_enable = (echo_cnt_q != '0);
                bus.led_color  = echo_col_q;
            end
            S_LOSE: begin
                bus.busy = 1'b0;
                bus.lose = 1'b1;
            end
            S_WIN: begin
                bus.busy = 1'b0;
                bus.win  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench for simon_sequencer with small timing parameters.
// Build with SIMON_TIMEOUT_EN defined to cover the entry timeout.
`timescale 1ns/1ps
module tb_simon_sequencer;

    localparam int MAX_LEN       = 4;
    localparam int STEP_TICKS    = 4;
    localparam int GAP_TICKS     = 2;
    localparam int TIMEOUT_TICKS = 20;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [1:0] pat [4];

    always #5 clk = ~clk;

    simon_if sif ();

    simon_sequencer #(
        .MAX_LEN       (MAX_LEN),
        .STEP_TICKS    (STEP_TICKS),
        .GAP_TICKS     (GAP_TICKS),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called while the DUT sits in APPEND.
    task automatic append_chk(input logic [1:0] col, input int lvl_before);
        check_val("append_step", 32'(sif.rnd_step), 1);
        check_val("append_level", 32'(sif.level), 32'(lvl_before));
        sif.rnd_color = col;
    endtask

    // Walks the playback of lvl colors from APPEND into PLAYER_WAIT,
    // holding noise on the buttons throughout the playback.
    task automatic play(input int lvl, input logic [3:0] noise);
        int lit = 0;
        int colbad = 0;
        sif.btn_pressed = noise;
        for (int s = 0; s < lvl; s++) begin
            for (int c = 0; c < STEP_TICKS + GAP_TICKS; c++) begin
                tick();
                if (s == 0 && c == 0) begin
                    check_val("step_pulse", 32'(sif.rnd_step), 0);
                    check_val("play_level", 32'(sif.level), 32'(lvl));
                end
                if (sif.led_enable) lit++;
                if (c < STEP_TICKS && sif.led_color !== pat[s]) colbad++;
            end
        end
        sif.btn_pressed = 4'b0000;
        tick();
        check_val("play_lit", 32'(lit), 32'(lvl * STEP_TICKS));
        check_val("play_color", 32'(colbad), 0);
        check_val("wait_busy", 32'(sif.busy), 1);
        check_val("wait_dark", 32'(sif.led_enable), 0);
    endtask

    task automatic press(input logic [3:0] b);
        sif.btn_pressed = b;
        tick();
        sif.btn_pressed = 4'b0000;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b0;
        sif.start       = 1'b0;
        sif.btn_pressed = 4'b0000;
        sif.rnd_color   = 2'd0;
        tick();
        tick();
        check_val("rst_busy", 32'(sif.busy), 0);
        check_val("rst_level", 32'(sif.level), 0);
        check_val("rst_led", 32'(sif.led_enable), 0);
        check_val("rst_step", 32'(sif.rnd_step), 0);
        check_val("rst_lose", 32'(sif.lose), 0);
        check_val("rst_win", 32'(sif.win), 0);
        reset = 1'b1;
        tick();
        check_val("idle_busy", 32'(sif.busy), 0);

        // Full game to WIN with pattern 2,0,1,3
        pat = '{2'd2, 2'd0, 2'd1, 2'd3};
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            append_chk(pat[r-1], r - 1);
            play(r, 4'b0000);
            for (int i = 0; i < r; i++) begin
                sif.btn_pressed = 4'b0001 << pat[i];
                tick();
                if (r == 1) begin
                    check_val("echo_en", 32'(sif.led_enable), 1);
                    check_val("echo_col", 32'(sif.led_color), 32'(pat[0]));
                end
                sif.btn_pressed = 4'b0000;
                tick();
                if (i < r - 1) begin
                    check_val("mid_busy", 32'(sif.busy), 1);
                    check_val("mid_lose", 32'(sif.lose), 0);
                end
            end
        end
        check_val("win_flag", 32'(sif.win), 1);
        check_val("win_level", 32'(sif.level), 4);
        check_val("win_busy", 32'(sif.busy), 0);
        check_val("win_led", 32'(sif.led_enable), 0);

        // Wrong second press in round 2 (pattern 2,0)
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        check_val("restart_win", 32'(sif.win), 0);
        pat = '{2'd2, 2'd0, 2'd0, 2'd0};
        append_chk(2'd2, 0);
        play(1, 4'b0000);
        press(4'b0100);
        append_chk(2'd0, 1);
        play(2, 4'b0000);
        press(4'b0100);
        check_val("r2_first_ok", 32'(sif.busy), 1);
        press(4'b1000);
        check_val("lose_flag", 32'(sif.lose), 1);
        check_val("lose_level", 32'(sif.level), 2);
        check_val("lose_busy", 32'(sif.busy), 0);

        // New game from LOSE, noisy buttons during playback
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        pat = '{2'd1, 2'd3, 2'd0, 2'd0};
        append_chk(2'd1, 0);
        play(1, 4'b1111);
        check_val("newgame_level", 32'(sif.level), 1);
        check_val("newgame_lose", 32'(sif.lose), 0);
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        check_val("start_busy_step", 32'(sif.rnd_step), 0);
        check_val("start_busy_level", 32'(sif.level), 1);
        press(4'b0010);
        append_chk(2'd3, 1);
        play(2, 4'b0000);
        press(4'b0101);
        check_val("double_lose", 32'(sif.lose), 1);
        check_val("double_level", 32'(sif.level), 2);

        // Entry timeout behaviour
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        pat = '{2'd0, 2'd0, 2'd0, 2'd0};
        append_chk(2'd0, 0);
        play(1, 4'b0000);
`ifdef SIMON_TIMEOUT_EN
        repeat (TIMEOUT_TICKS - 1) tick();
        check_val("to_before_busy", 32'(sif.busy), 1);
        check_val("to_before_lose", 32'(sif.lose), 0);
        tick();
        check_val("to_lose", 32'(sif.lose), 1);
`else
        repeat (1000) tick();
        check_val("noto_busy", 32'(sif.busy), 1);
        check_val("noto_lose", 32'(sif.lose), 0);
        press(4'b0001);
        check_val("noto_accept", 32'(sif.rnd_step), 1);
`endif

        // Reset during SIMON_PLAY
        reset = 1'b0;
        tick();
        reset     = 1'b1;
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        pat = '{2'd2, 2'd0, 2'd0, 2'd0};
        append_chk(2'd2, 0);
        tick();
        tick();
        check_val("pre_reset_lit", 32'(sif.led_enable), 1);
        reset = 1'b0;
        tick();
        check_val("mid_rst_led", 32'(sif.led_enable), 0);
        check_val("mid_rst_col", 32'(sif.led_color), 0);
        check_val("mid_rst_step", 32'(sif.rnd_step), 0);
        check_val("mid_rst_level", 32'(sif.level), 0);
        check_val("mid_rst_busy", 32'(sif.busy), 0);
        check_val("mid_rst_lose", 32'(sif.lose), 0);
        check_val("mid_rst_win", 32'(sif.win), 0);
        reset     = 1'b1;
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        check_val("post_rst_start", 32'(sif.rnd_step), 1);
        check_val("post_rst_busy", 32'(sif.busy), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
